label_merge_table: RTL and testbench

Equivalence-resolution stage directly downstream of the first-pass connected-component labeler. It captures merge requests (label pairs) raised during the raster scan and links them into a 64-entry union table. At end of frame it flattens the table so every label maps to its lowest equivalent label. It then serves single-cycle-latency lookups to the second-pass relabel stage that reads the label RAM.

---
 rtl/label_merge_table.sv | 205 ++++++++++++++++++++
 tb/tb_label_merge_table.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/label_merge_table.sv
// Union-find equivalence table for the two-pass connected-component labeler.
// Optional feature macro: LABEL_MERGE_DEDUP_EN (drops identical consecutive merge pairs).
module label_merge_table #(
  parameter int DEPTH = 16
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       iframe_start,
  input  logic       iresolve,
  input  logic [5:0] imerge_a,
  input  logic [5:0] imerge_b,
  input  logic       ifinish,
  input  logic [5:0] ilookup_label,
  output logic [5:0] olookup_label,
  output logic       oready,
  output logic       obusy,
  output logic       ooverflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [2:0] {IDLE, POP, FIND_A, FIND_B, LINK, FLATTEN, READY} state_t;

  state_t state_reg, state_next;

  logic [5:0]    parent_reg [64];
  logic [11:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, wr_addr;
  logic [AW:0]   count_reg;
  logic [5:0]    ra_reg, rb_reg, ra_next, rb_next;
  logic [5:0]    idx_reg;
  logic          fin_prev_reg, fin_pend_reg, overflow_reg;
  logic [5:0]    lookup_reg;

  logic [5:0]  pair_lo, pair_hi;
  logic [11:0] fifo_head;
  logic        pair_ok, dedup_hit, drop_state, push_req, push_ok, pop, full, ovf_set;
  logic        fin_edge, flatten_entry;
  logic        tbl_we;
  logic [5:0]  tbl_addr, tbl_data;

  // Merge-pair filter and normalisation (smaller label first)
  assign pair_lo    = (imerge_a < imerge_b) ? imerge_a : imerge_b;
  assign pair_hi    = (imerge_a < imerge_b) ? imerge_b : imerge_a;
  assign pair_ok    = iresolve && (imerge_a != 6'd0) && (imerge_b != 6'd0) && (imerge_a != imerge_b);
  assign drop_state = ((state_reg == FLATTEN) || (state_reg == READY)) && !iframe_start;
  assign push_req   = pair_ok && !dedup_hit && !drop_state;
  assign full       = (count_reg == FULL_CNT);
  assign pop        = (state_reg == POP) && !iframe_start;
  assign push_ok    = push_req && (!full || pop || iframe_start);
  assign ovf_set    = push_req && full && !pop && !iframe_start;
  assign wr_addr    = iframe_start ? '0 : wr_ptr_reg;
  assign fifo_head  = fifo_mem[rd_ptr_reg];

`ifdef LABEL_MERGE_DEDUP_EN
  logic        dedup_valid_reg;
  logic [11:0] dedup_pair_reg;

  assign dedup_hit = dedup_valid_reg && !iframe_start && (dedup_pair_reg == {pair_lo, pair_hi});

  always_ff @(posedge iclk) begin
    if (irst || iframe_start) begin
      dedup_valid_reg <= 1'b0;
      dedup_pair_reg  <= '0;
    end else if (push_ok) begin
      dedup_valid_reg <= 1'b1;
      dedup_pair_reg  <= {pair_lo, pair_hi};
    end
  end
`else
  assign dedup_hit = 1'b0;
`endif

  always_ff @(posedge iclk) begin
    if (push_ok && !irst)
      fifo_mem[wr_addr] <= {pair_lo, pair_hi};
  end

  // A frame start empties the FIFO but still accepts the same-cycle pair into slot 0
  always_ff @(posedge iclk) begin
    if (irst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (iframe_start) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= push_ok ? AW'(1) : '0;
      count_reg  <= push_ok ? (AW+1)'(1) : '0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign fin_edge      = ifinish && !fin_prev_reg;
  assign flatten_entry = (state_next == FLATTEN) && (state_reg != FLATTEN);

  always_comb begin
    state_next = state_reg;
    ra_next    = ra_reg;
    rb_next    = rb_reg;
    tbl_we     = 1'b0;
    tbl_addr   = 6'd0;
    tbl_data   = 6'd0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0)
          state_next = POP;
        else if (fin_pend_reg)
          state_next = FLATTEN;
      end
      POP: begin
        ra_next    = fifo_head[11:6];
        rb_next    = fifo_head[5:0];
        state_next = FIND_A;
      end
      FIND_A: begin
        if (parent_reg[ra_reg] == ra_reg)
          state_next = FIND_B;
        else
          ra_next = parent_reg[ra_reg];
      end
      FIND_B: begin
        if (parent_reg[rb_reg] == rb_reg)
          state_next = LINK;
        else
          rb_next = parent_reg[rb_reg];
      end
      LINK: begin
        // Always hang the higher root under the lower one so links point downward
        if (ra_reg != rb_reg) begin
          tbl_we   = 1'b1;
          tbl_addr = (ra_reg > rb_reg) ? ra_reg : rb_reg;
          tbl_data = (ra_reg > rb_reg) ? rb_reg : ra_reg;
        end
        state_next = IDLE;
      end
      FLATTEN: begin
        tbl_we   = 1'b1;
        tbl_addr = idx_reg;
        tbl_data = parent_reg[parent_reg[idx_reg]];
        if (idx_reg == 6'd63)
          state_next = READY;
      end
      READY: state_next = READY;
      default: state_next = IDLE;
    endcase
    if (iframe_start)
      state_next = IDLE;
  end

  always_ff @(posedge iclk) begin
    if (irst || iframe_start) begin
      for (int i = 0; i < 64; i++)
        parent_reg[i] <= 6'(i);
    end else if (tbl_we) begin
      parent_reg[tbl_addr] <= tbl_data;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_reg    <= IDLE;
      ra_reg       <= 6'd0;
      rb_reg       <= 6'd0;
      idx_reg      <= 6'd1;
      fin_prev_reg <= 1'b0;
      fin_pend_reg <= 1'b0;
      overflow_reg <= 1'b0;
      lookup_reg   <= 6'd0;
    end else begin
      state_reg    <= state_next;
      ra_reg       <= ra_next;
      rb_reg       <= rb_next;
      fin_prev_reg <= ifinish;
      idx_reg      <= (state_reg == FLATTEN) ? idx_reg + 1'b1 : 6'd1;
      if (iframe_start)
        fin_pend_reg <= 1'b0;
      else if (fin_edge)
        fin_pend_reg <= 1'b1;
      else if (flatten_entry)
        fin_pend_reg <= 1'b0;
      if (iframe_start)
        overflow_reg <= 1'b0;
      else if (ovf_set)
        overflow_reg <= 1'b1;
      if (state_reg == READY)
        lookup_reg <= parent_reg[ilookup_label];
    end
  end

  assign olookup_label = lookup_reg;
  assign oready        = (state_reg == READY);
  assign obusy         = (count_reg != '0) || ((state_reg != IDLE) && (state_reg != READY));
  assign ooverflow     = overflow_reg;

endmodule

// File: tb/tb_label_merge_table.sv
// Directed bench for label_merge_table: merges, flatten timing, filters, overflow, dedup, frame restart.
module tb_label_merge_table;

  logic       iclk = 1'b0;
  logic       irst, iframe_start, iresolve, ifinish;
  logic [5:0] imerge_a, imerge_b, ilookup_label;
  logic [5:0] olookup_label;
  logic       oready, obusy, ooverflow;

  int checks = 0;
  int failures = 0;

  label_merge_table #(.DEPTH(16)) dut (
    .iclk(iclk), .irst(irst), .iframe_start(iframe_start), .iresolve(iresolve),
    .imerge_a(imerge_a), .imerge_b(imerge_b), .ifinish(ifinish),
    .ilookup_label(ilookup_label), .olookup_label(olookup_label),
    .oready(oready), .obusy(obusy), .ooverflow(ooverflow)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic push(input logic [5:0] a, input logic [5:0] b);
    imerge_a = a;
    imerge_b = b;
    iresolve = 1'b1;
    tick();
    iresolve = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [5:0] lbl, input logic [5:0] exp);
    ilookup_label = lbl;
    tick();
    $display("lookup %0d -> %0d (expect %0d)", lbl, olookup_label, exp);
    check(tag, olookup_label, exp);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (obusy && n < budget) begin
      tick();
      n++;
    end
    check(tag, obusy, 1'b0);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (!oready && n < budget) begin
      tick();
      n++;
    end
    check(tag, oready, 1'b1);
  endtask

  task automatic new_frame();
    iframe_start = 1'b1;
    ifinish = 1'b0;
    tick();
    iframe_start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    irst = 1'b1; iframe_start = 1'b0; iresolve = 1'b0; ifinish = 1'b0;
    imerge_a = 6'd0; imerge_b = 6'd0; ilookup_label = 6'd0;
    tick(); tick(); tick();
    irst = 1'b0;
    check("rst_lookup", olookup_label, 6'd0);
    check("rst_ready", oready, 1'b0);
    check("rst_busy", obusy, 1'b0);
    check("rst_overflow", ooverflow, 1'b0);

    // Finish with no merges: edge sampled, one IDLE cycle, then 63 FLATTEN cycles
    ifinish = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!oready && n < 200);
    $display("empty frame ready after %0d edges", n);
    check("finish_latency", n, 65);
    lookup("empty_lk5", 6'd5, 6'd5);
    lookup("empty_lk0", 6'd0, 6'd0);
    push(6'd1, 6'd2);
    check("ready_drop_busy", obusy, 1'b0);
    check("ready_drop_ovf", ooverflow, 1'b0);
    lookup("ready_drop_lk2", 6'd2, 6'd2);

    // Chain of merges; the last pair shares its cycle with the finish edge
    new_frame();
    check("frame_clears_ready", oready, 1'b0);
    push(6'd3, 6'd7);
    push(6'd9, 6'd7);
    imerge_a = 6'd2; imerge_b = 6'd9; iresolve = 1'b1; ifinish = 1'b1;
    tick();
    iresolve = 1'b0;
    wait_ready("chain_ready", 600);
    lookup("chain_lk2", 6'd2, 6'd2);
    lookup("chain_lk3", 6'd3, 6'd2);
    lookup("chain_lk7", 6'd7, 6'd2);
    lookup("chain_lk9", 6'd9, 6'd2);
    lookup("chain_lk4", 6'd4, 6'd4);

    // Filtered pairs never reach the FIFO
    new_frame();
    push(6'd0, 6'd5);
    check("filter_zero_busy", obusy, 1'b0);
    push(6'd6, 6'd6);
    check("filter_same_busy", obusy, 1'b0);
    tick();
    check("filter_busy_late", obusy, 1'b0);
    ifinish = 1'b1;
    wait_ready("filter_ready", 200);
    lookup("filter_lk5", 6'd5, 6'd5);
    lookup("filter_lk6", 6'd6, 6'd6);

    // Build a 23-deep chain 63->62->...->40, then stall the FSM on it while flooding the FIFO
    new_frame();
    for (int k = 62; k >= 40; k--) begin
      push(6'(k), 6'(k + 1));
      wait_idle("chain_build_idle", 50);
    end
    push(6'd1, 6'd63);
    for (int k = 1; k <= 17; k++) begin
      if (k == 17)
        push(6'd34, 6'd35);
      else
        push(6'(k + 1), 6'(k + 17));
      if (k == 16)
        check("ovf_at_full", ooverflow, 1'b0);
    end
    $display("flood done overflow=%0d", ooverflow);
    check("ovf_set", ooverflow, 1'b1);
    wait_idle("ovf_drain_idle", 1000);
    ifinish = 1'b1;
    wait_ready("ovf_ready", 200);
    check("ovf_sticky", ooverflow, 1'b1);
    lookup("ovf_lk63", 6'd63, 6'd1);
    lookup("ovf_lk40", 6'd40, 6'd1);
    lookup("ovf_lk18", 6'd18, 6'd2);
    lookup("ovf_lk33", 6'd33, 6'd17);
    lookup("ovf_lk34", 6'd34, 6'd34);
    lookup("ovf_lk35", 6'd35, 6'd35);
    new_frame();
    check("frame_clears_ovf", ooverflow, 1'b0);

    // Forty identical back-to-back pairs followed by a new one
    for (int k = 0; k < 40; k++)
      push(6'd4, 6'd8);
    push(6'd4, 6'd9);
`ifdef LABEL_MERGE_DEDUP_EN
    check("dedup_no_ovf", ooverflow, 1'b0);
    wait_idle("dedup_idle", 200);
    ifinish = 1'b1;
    wait_ready("dedup_ready", 200);
    lookup("dedup_lk8", 6'd8, 6'd4);
    lookup("dedup_lk9", 6'd9, 6'd4);
`else
    check("nodedup_ovf", ooverflow, 1'b1);
    wait_idle("nodedup_idle", 1000);
    ifinish = 1'b1;
    wait_ready("nodedup_ready", 200);
    lookup("nodedup_lk8", 6'd8, 6'd4);
`endif

    // Frame restart in the middle of FLATTEN with a same-cycle merge pair
    new_frame();
    push(6'd3, 6'd7);
    wait_idle("restart_idle", 100);
    ifinish = 1'b1;
    for (int k = 0; k < 12; k++)
      tick();
    check("mid_flatten_busy", obusy, 1'b1);
    iframe_start = 1'b1; ifinish = 1'b0;
    imerge_a = 6'd10; imerge_b = 6'd12; iresolve = 1'b1;
    tick();
    iframe_start = 1'b0; iresolve = 1'b0;
    check("restart_ready", oready, 1'b0);
    check("restart_pair_busy", obusy, 1'b1);
    wait_idle("restart_drain", 100);
    ifinish = 1'b1;
    wait_ready("restart_ready2", 200);
    lookup("restart_lk12", 6'd12, 6'd10);
    lookup("restart_lk10", 6'd10, 6'd10);
    lookup("restart_lk7", 6'd7, 6'd7);
    lookup("restart_lk3", 6'd3, 6'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
